control_pipe: RTL and testbench
===============================

CONTROL_PIPE -- requirements
Module: control_pipe

Interface
REQ-001 Parameter CLEAR_ON_FLUSH, default 1: 1 zeroes the entire E control word on flush; 0 zeroes only RegW, RegWV, MemW and Branch.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 CtrlD  input  ctrl_t (11)  Decode-stage control from main decoder: RegW, RegWV, MemtoReg, MemW, MemSrc, MemData, MemDataV, VecData, Branch, ALUOp, ALUSrc.
REQ-005 BranchTypeD  input  2  00 beq, 01 bgt, 10 unconditional b, 11 reserved.
REQ-006 StallE  input  1  hazard unit: hold E register.
REQ-007 FlushE  input  1  hazard unit: insert bubble into E.
REQ-008 ZeroE  input  1  ALU zero flag for the instruction in E.
REQ-009 GreaterE  input  1  ALU signed-greater flag for the instruction in E.
REQ-010 CtrlE  output  ctrl_t  control word of the instruction in Execute.
REQ-011 CtrlM  output  ctrl_t  control word of the instruction in Memory.
REQ-012 CtrlW  output  ctrl_t  control word of the instruction in Writeback.
REQ-013 BranchTakenE  output  1  combinational; branch in E resolves taken.

Function
REQ-014 Three register stages SHALL exist (D->E, E->M, M->W), each one cycle; CtrlD appears on CtrlE one edge later, on CtrlM two, on CtrlW three, absent stall/flush.
REQ-015 The E register SHALL also hold BranchTypeE (2 bits), registered with CtrlD under identical stall/flush rules.
REQ-016 FlushE=1 SHALL load a bubble into E per CLEAR_ON_FLUSH; a bubble always has RegW=RegWV=MemW=Branch=0.
REQ-017 StallE=1 with FlushE=0 SHALL hold the E register; M and W registers keep advancing, and M SHALL receive a bubble that cycle.
REQ-018 FlushE and StallE both asserted: flush SHALL win.
REQ-019 BranchTakenE SHALL be CtrlE.Branch AND (type 00: ZeroE; type 01: GreaterE; type 10: 1; type 11: 0).
REQ-020 BranchTakenE SHALL be 0 whenever CtrlE.Branch=0, regardless of flags.
REQ-021 X bits in CtrlD (decoder don't-cares) SHALL be registered unchanged, except RegW, RegWV, MemW and Branch, which SHALL be forced to 0 when X/Z so that no side effect is triggered.
REQ-022 M->W transfer SHALL be unconditional; no stall or flush acts on M or W.

Reset
REQ-023 rst=1 at a clock edge SHALL clear E, M, W registers and BranchTypeE to all-zero; CtrlE, CtrlM and CtrlW read 0 from that edge; BranchTakenE is 0.
REQ-024 rst SHALL dominate StallE and FlushE; reset asserted mid-stream discards all in-flight control with no write or branch side effects.
REQ-025 The first instruction after rst deasserts SHALL reach CtrlE on the next edge.

Structure
REQ-026 ctrl_t (packed struct, field order as REQ-004), the branch_type_t enum, and the bubble constant SHALL live in the shared processor package, also used by main_decoder's consumer logic.
REQ-027 One sub-module, ctrl_stage_reg (one ctrl_t register with en/clr inputs), SHALL be instantiated three times; branch resolution stays in control_pipe.

Verification
REQ-028 Scenario: add (RegW=1, ALUOp=1) at D for one cycle, then bubbles -> CtrlE.RegW=1 at cycle 1, CtrlM.RegW=1 at cycle 2, CtrlW.RegW=1 at cycle 3, 0 elsewhere.
REQ-029 Scenario: beq in E with ZeroE=1 -> BranchTakenE=1; with ZeroE=0, GreaterE=1 -> 0; bgt with GreaterE=1 -> 1; b with both flags 0 -> 1; type 11 -> 0.
REQ-030 Scenario: str (MemW=1) in D, StallE=1 for 2 cycles -> CtrlE holds MemW=1 for 3 cycles; CtrlM shows MemW=0 for 2 cycles, then MemW=1 once.
REQ-031 Scenario: FlushE=1 and StallE=1 together with ldr in D -> next CtrlE.RegW=0, MemtoReg=0 (CLEAR_ON_FLUSH=1).
REQ-032 Scenario: rst pulsed while ldrv sits in M -> CtrlW.RegWV=0 on the following cycle; all outputs 0.
REQ-033 Scenario: CtrlD with RegW=X, MemW=X -> CtrlE.RegW=0, MemW=0; remaining X fields pass through.

Source files
------------

// File: rtl/control_pipe_pkg.sv
// Shared processor package: control word layout, branch types
// and the helpers used to build pipeline bubbles.
package control_pipe_pkg;

    typedef struct packed {
        logic RegW;
        logic RegWV;
        logic MemtoReg;
        logic MemW;
        logic MemSrc;
        logic MemData;
        logic MemDataV;
        logic VecData;
        logic Branch;
        logic ALUOp;
        logic ALUSrc;
    } ctrl_t;

    typedef enum logic [1:0] {
        BR_EQ  = 2'b00,
        BR_GT  = 2'b01,
        BR_AL  = 2'b10,
        BR_RSV = 2'b11
    } branch_type_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // Side-effect bits only count when they are a definite 1;
    // decoder don't-cares on them must never cause a write or branch.
    function automatic ctrl_t ctrl_sanitize(input ctrl_t c);
        ctrl_t r;
        r        = c;
        r.RegW   = (c.RegW === 1'b1);
        r.RegWV  = (c.RegWV === 1'b1);
        r.MemW   = (c.MemW === 1'b1);
        r.Branch = (c.Branch === 1'b1);
        return r;
    endfunction

    // Bubble derived from a live word: either all-zero, or the
    // same word with every side-effect bit killed.
    function automatic ctrl_t ctrl_bubble(input ctrl_t c,
                                          input logic clear_all);
        ctrl_t r;
        if (clear_all) begin
            r = CTRL_BUBBLE;
        end else begin
            r        = c;
            r.RegW   = 1'b0;
            r.RegWV  = 1'b0;
            r.MemW   = 1'b0;
            r.Branch = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/control_pipe_ctrl_stage_reg.sv
// One pipeline control-word register with enable and clear.
// Clear and reset load the all-zero bubble.
module ctrl_stage_reg
    import control_pipe_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  i_en,
    input  logic  i_clr,
    input  ctrl_t i_d,
    output ctrl_t o_q
);

    ctrl_t r_q;

    // Register the control word; clear beats enable
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_q <= CTRL_BUBBLE;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/control_pipe.sv
// Control pipeline D->E->M->W with stall/flush on E and
// branch resolution for the instruction in Execute.
module control_pipe
    import control_pipe_pkg::*;
#(
    parameter bit CLEAR_ON_FLUSH = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  ctrl_t      CtrlD,
    input  logic [1:0] BranchTypeD,
    input  logic       StallE,
    input  logic       FlushE,
    input  logic       ZeroE,
    input  logic       GreaterE,
    output ctrl_t      CtrlE,
    output ctrl_t      CtrlM,
    output ctrl_t      CtrlW,
    output logic       BranchTakenE
);

    ctrl_t        w_ctrl_d;
    ctrl_t        w_e_d;
    ctrl_t        w_m_d;
    logic         w_e_en;
    logic         w_e_clr;
    logic         w_m_clr;
    logic         w_stall_only;
    logic         w_cond;
    branch_type_t r_br_type;

    assign w_ctrl_d     = ctrl_sanitize(CtrlD);
    assign w_stall_only = StallE && !FlushE;

    // Flush wins over stall: E always loads when flushing
    assign w_e_en  = !StallE || FlushE;
    assign w_e_clr = FlushE && CLEAR_ON_FLUSH;
    assign w_e_d   = FlushE ? ctrl_bubble(w_ctrl_d, 1'b0)
                            : w_ctrl_d;

    // A held E must not issue twice, so M takes a bubble
    assign w_m_clr = w_stall_only && CLEAR_ON_FLUSH;
    assign w_m_d   = w_stall_only ? ctrl_bubble(CtrlE, 1'b0)
                                  : CtrlE;

    ctrl_stage_reg u_reg_e (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_e_en),
        .i_clr (w_e_clr),
        .i_d   (w_e_d),
        .o_q   (CtrlE)
    );

    ctrl_stage_reg u_reg_m (
        .clk   (clk),
        .rst   (rst),
        .i_en  (1'b1),
        .i_clr (w_m_clr),
        .i_d   (w_m_d),
        .o_q   (CtrlM)
    );

    ctrl_stage_reg u_reg_w (
        .clk   (clk),
        .rst   (rst),
        .i_en  (1'b1),
        .i_clr (1'b0),
        .i_d   (CtrlM),
        .o_q   (CtrlW)
    );

    // Branch type travels with the E control word
    always_ff @(posedge clk) begin
        if (rst || FlushE) begin
            r_br_type <= BR_EQ;
        end else if (!StallE) begin
            r_br_type <= branch_type_t'(BranchTypeD);
        end
    end

    // Resolve the branch condition from the ALU flags
    always_comb begin
        w_cond = 1'b0;
        unique case (r_br_type)
            BR_EQ:  w_cond = ZeroE;
            BR_GT:  w_cond = GreaterE;
            BR_AL:  w_cond = 1'b1;
            BR_RSV: w_cond = 1'b0;
        endcase
    end

    assign BranchTakenE = CtrlE.Branch & w_cond;

endmodule

// File: tb/tb_control_pipe.sv
// Directed self-checking bench for control_pipe.
// Inputs change and outputs are sampled 1ns after each rising edge.
`timescale 1ns/1ps
module tb_control_pipe;
    import control_pipe_pkg::*;

    logic       clk;
    logic       rst;
    ctrl_t      CtrlD;
    logic [1:0] BranchTypeD;
    logic       StallE;
    logic       FlushE;
    logic       ZeroE;
    logic       GreaterE;
    ctrl_t      CtrlE;
    ctrl_t      CtrlM;
    ctrl_t      CtrlW;
    logic       BranchTakenE;

    int n_checks = 0;
    int n_errors = 0;

    ctrl_t c_add;
    ctrl_t c_str;
    ctrl_t c_ldr;
    ctrl_t c_ldrv;
    ctrl_t c_br;
    ctrl_t c_xx;

    control_pipe #(.CLEAR_ON_FLUSH(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .CtrlD        (CtrlD),
        .BranchTypeD  (BranchTypeD),
        .StallE       (StallE),
        .FlushE       (FlushE),
        .ZeroE        (ZeroE),
        .GreaterE     (GreaterE),
        .CtrlE        (CtrlE),
        .CtrlM        (CtrlM),
        .CtrlW        (CtrlW),
        .BranchTakenE (BranchTakenE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [15:0] got,
                         input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic br_case(input string tag,
                           input logic brn,
                           input logic [1:0] bt,
                           input logic z,
                           input logic g,
                           input logic exp);
        ctrl_t c;
        c           = c_br;
        c.Branch    = brn;
        CtrlD       = c;
        BranchTypeD = bt;
        tick();
        CtrlD       = CTRL_BUBBLE;
        BranchTypeD = 2'b00;
        ZeroE       = z;
        GreaterE    = g;
        #1;
        check(tag, 16'(BranchTakenE), 16'(exp));
        ZeroE    = 1'b0;
        GreaterE = 1'b0;
    endtask

    initial begin
        c_add = '0; c_add.RegW = 1'b1; c_add.ALUOp = 1'b1;
        c_str = '0; c_str.MemW = 1'b1; c_str.ALUSrc = 1'b1;
        c_ldr = '0; c_ldr.RegW = 1'b1; c_ldr.MemtoReg = 1'b1;
        c_ldr.ALUSrc = 1'b1;
        c_ldrv = '0; c_ldrv.RegWV = 1'b1; c_ldrv.MemtoReg = 1'b1;
        c_ldrv.MemDataV = 1'b1;
        c_br = '0; c_br.Branch = 1'b1; c_br.ALUOp = 1'b1;

        rst = 1'b1; CtrlD = c_add; BranchTypeD = 2'b10;
        StallE = 1'b0; FlushE = 1'b0; ZeroE = 1'b1; GreaterE = 1'b1;
        tick();
        tick();
        check("rst_e", 16'(CtrlE), 16'h0);
        check("rst_m", 16'(CtrlM), 16'h0);
        check("rst_w", 16'(CtrlW), 16'h0);
        check("rst_bt", 16'(BranchTakenE), 16'h0);
        ZeroE = 1'b0; GreaterE = 1'b0;

        // add flows through, first instruction after reset
        rst = 1'b0; CtrlD = c_add; BranchTypeD = 2'b00;
        tick();
        CtrlD = CTRL_BUBBLE;
        check("add_c1_e", 16'(CtrlE), 16'(c_add));
        check("add_c1_m", 16'(CtrlM.RegW), 16'h0);
        check("add_c1_w", 16'(CtrlW.RegW), 16'h0);
        tick();
        check("add_c2_e", 16'(CtrlE.RegW), 16'h0);
        check("add_c2_m", 16'(CtrlM.RegW), 16'h1);
        check("add_c2_w", 16'(CtrlW.RegW), 16'h0);
        tick();
        check("add_c3_e", 16'(CtrlE.RegW), 16'h0);
        check("add_c3_m", 16'(CtrlM.RegW), 16'h0);
        check("add_c3_w", 16'(CtrlW), 16'(c_add));
        tick();
        check("add_c4_w", 16'(CtrlW.RegW), 16'h0);

        // branch resolution
        br_case("beq_z1", 1'b1, 2'b00, 1'b1, 1'b0, 1'b1);
        br_case("beq_z0g1", 1'b1, 2'b00, 1'b0, 1'b1, 1'b0);
        br_case("bgt_g1", 1'b1, 2'b01, 1'b0, 1'b1, 1'b1);
        br_case("bgt_g0", 1'b1, 2'b01, 1'b1, 1'b0, 1'b0);
        br_case("b_always", 1'b1, 2'b10, 1'b0, 1'b0, 1'b1);
        br_case("b_rsv", 1'b1, 2'b11, 1'b1, 1'b1, 1'b0);
        br_case("nobr_b", 1'b0, 2'b10, 1'b1, 1'b1, 1'b0);
        br_case("nobr_eq", 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);

        // str held for two stall cycles
        CtrlD = c_str;
        tick();
        CtrlD = c_add;
        StallE = 1'b1;
        check("stl_c1_e", 16'(CtrlE.MemW), 16'h1);
        tick();
        check("stl_c2_e", 16'(CtrlE.MemW), 16'h1);
        check("stl_c2_m", 16'(CtrlM.MemW), 16'h0);
        tick();
        check("stl_c3_e", 16'(CtrlE), 16'(c_str));
        check("stl_c3_m", 16'(CtrlM), 16'h0);
        StallE = 1'b0;
        CtrlD = CTRL_BUBBLE;
        tick();
        check("stl_c4_e", 16'(CtrlE.MemW), 16'h0);
        check("stl_c4_m", 16'(CtrlM), 16'(c_str));
        tick();
        check("stl_c5_m", 16'(CtrlM.MemW), 16'h0);

        // flush beats stall; E still advances into M
        CtrlD = c_add;
        tick();
        CtrlD = c_ldr; StallE = 1'b1; FlushE = 1'b1;
        tick();
        StallE = 1'b0; FlushE = 1'b0; CtrlD = CTRL_BUBBLE;
        check("fl_e_regw", 16'(CtrlE.RegW), 16'h0);
        check("fl_e_mtr", 16'(CtrlE.MemtoReg), 16'h0);
        check("fl_e_all", 16'(CtrlE), 16'h0);
        check("fl_m_adv", 16'(CtrlM), 16'(c_add));

        // reset while ldrv sits in M, with stall and flush high
        CtrlD = c_ldrv;
        tick();
        CtrlD = c_str;
        tick();
        check("ldrv_in_m", 16'(CtrlM), 16'(c_ldrv));
        rst = 1'b1; StallE = 1'b1; FlushE = 1'b1; CtrlD = c_add;
        BranchTypeD = 2'b10;
        tick();
        rst = 1'b0; StallE = 1'b0; FlushE = 1'b0;
        CtrlD = CTRL_BUBBLE; BranchTypeD = 2'b00;
        ZeroE = 1'b1; GreaterE = 1'b1;
        #1;
        check("mrst_w_rwv", 16'(CtrlW.RegWV), 16'h0);
        check("mrst_e", 16'(CtrlE), 16'h0);
        check("mrst_m", 16'(CtrlM), 16'h0);
        check("mrst_w", 16'(CtrlW), 16'h0);
        check("mrst_bt", 16'(BranchTakenE), 16'h0);
        ZeroE = 1'b0; GreaterE = 1'b0;
        tick();
        check("post_rst_w", 16'(CtrlW), 16'h0);

        // don't-care side-effect bits are forced low
        c_xx = '0;
        c_xx.RegW = 1'bx; c_xx.MemW = 1'bx;
        c_xx.ALUOp = 1'b1; c_xx.MemSrc = 1'b1;
        CtrlD = c_xx;
        tick();
        CtrlD = CTRL_BUBBLE;
        check("x_regw", 16'(CtrlE.RegW), 16'h0);
        check("x_memw", 16'(CtrlE.MemW), 16'h0);
        check("x_aluop", 16'(CtrlE.ALUOp), 16'h1);
        check("x_memsrc", 16'(CtrlE.MemSrc), 16'h1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
